seq_detect_frame_ctrl: RTL and testbench
========================================

// Module: seq_detect_frame_ctrl
// PURPOSE
//   Frame sequencer for dual_sequence_detector. Accepts a parallel frame and
//   optionally resets the detector first. Shifts the frame MSB-first onto the
//   detector's serial input x, one bit per clock, and collects y. Reports a
//   saturating hit count and a per-bit hit map, using a start/busy/done handshake.
// PARAMETERS
//   WIDTH    16  frame length in bits (>=2)
//   CNT_W    5   hit counter width; saturates at 2**CNT_W-1
//   DET_LAT  1   clocks from bit on det_x to its effect on det_y (0..3)
// PORTS
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous, active-low reset
//   start      in   1        request; sampled only in IDLE
//   frame      in   WIDTH    frame bits, captured on accepted start
//   clear_det  in   1        captured with start; 1 = pulse detector reset first
//   busy       out  1        high in CLR, SHIFT, DRAIN
//   done       out  1        one-cycle pulse, frame complete
//   hits       out  CNT_W    number of cycles with attributed det_y=1
//   hit_map    out  WIDTH    hit_map[j]=1 if det_y attributed to frame bit j
//   overflow   out  1        sticky; a hit arrived while hits was saturated
//   det_reset_n out 1        to detector reset_n = reset_n & ~clr_q
//   det_x      out  1        to detector x
//   det_y      in   1        from detector y
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - State is IDLE. busy, done, hits, hit_map, overflow and det_x are 0.
//   - det_reset_n=0, so the detector is reset too.
// - FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
// - IDLE, start=1 at edge E0:
//   - Latch frame into shift register, capture clear_det.
//   - Clear hits, hit_map and overflow.
//   - Go to CLR if clear_det=1, else SHIFT.
// - CLR: exactly 1 cycle. clr_q=1 (det_reset_n=0), det_x=0. Then go to SHIFT.
// - SHIFT: WIDTH cycles.
//   - Cycle k (k=0..WIDTH-1) drives det_x = frame[WIDTH-1-k].
//   - det_x comes from the shift-register MSB, gated by state==SHIFT (0 elsewhere).
//   - After the last bit, go to DRAIN if DET_LAT>0, else DONE.
// - DRAIN: DET_LAT cycles with det_x=0. Then go to DONE.
// - Hit attribution:
//   - det_y is sampled every cycle in SHIFT and DRAIN.
//   - A sample at overall cycle t (SHIFT cycle 0 = t0) belongs to bit k = t-t0-DET_LAT.
//   - Only 0<=k<WIDTH counts: hit_map[WIDTH-1-k]<=1, hits<=hits+1.
//   - det_y outside SHIFT/DRAIN, and samples with k<0, are ignored.
// - Saturation: a hit with hits==2**CNT_W-1 leaves hits unchanged and sets overflow.
// - DONE: 1 cycle. done=1, busy=0, then go to IDLE.
//   - hits, hit_map and overflow hold until the next accepted start.
// - Latency (clear_det=0):
//   - First bit is on det_x in the cycle after E0.
//   - done is high in the cycle WIDTH+DET_LAT+1 cycles after E0; +1 if clear_det=1.
// - start outside IDLE (including the DONE cycle) is ignored; there is no queueing.
//   frame and clear_det are don't-care except at the accepted start.
// - Reset mid-frame: the frame is abandoned immediately, with no done pulse.
//   All outputs take their reset values.
// - The detector is not reset between frames unless clear_det=1.
//   Its state carries across frames, including across back-to-back frames.
// TESTING (WIDTH=16, CNT_W=5, DET_LAT=1, det_y from a bench stub)
// 1. reset_n=0 mid-SHIFT -> busy=0, det_x=0, det_reset_n=0, hits=0 at once;
//    no done pulse after release.
// 2. start, frame=16'h5A5A, clear_det=0, stub: y=x delayed 1 clk ->
//    det_x stream 0101101001011010; done 18 clks after E0; hits=8; hit_map=16'h5A5A.
// 3. Same frame, clear_det=1 -> det_reset_n low exactly 1 clk right after E0;
//    first bit one clk later; done 19 clks after E0; same hits/hit_map.
// 4. frame=16'hFFFF, CNT_W=3 build, stub echo -> hits=7, overflow=1, hit_map=16'hFFFF.
// 5. start held high throughout, plus pulses mid-frame -> exactly one frame per
//    IDLE visit; mid-frame pulses have no effect; back-to-back frames separated
//    by the DONE cycle.
// 6. Stub y=1 constantly, frame=16'h0000 -> sample at SHIFT cycle 0 ignored;
//    hits=16 (SHIFT 1..15 plus DRAIN); y in IDLE/DONE not counted.

Source files
------------

// File: rtl/seq_detect_frame_ctrl_if.sv
// rtl/seq_detect_frame_ctrl_if.sv - request/result bundle between a frame source and the frame sequencer
//
// Ports (signals):
//   start      master->slave  request, honoured only while the sequencer is idle
//   frame      master->slave  WIDTH frame bits, captured on an accepted start
//   clear_det  master->slave  1 = pulse the detector reset before shifting
//   busy       slave->master  frame in progress (CLR, SHIFT, DRAIN)
//   done       slave->master  one-cycle completion pulse
//   hits       slave->master  saturating count of attributed detector hits
//   hit_map    slave->master  per-frame-bit hit flags
//   overflow   slave->master  sticky, a hit arrived while hits was saturated
interface seq_detect_frame_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] frame;
    logic             clear_det;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;
    logic [WIDTH-1:0] hit_map;
    logic             overflow;

    modport master (
        output start, frame, clear_det,
        input  busy, done, hits, hit_map, overflow
    );

    modport slave (
        input  start, frame, clear_det,
        output busy, done, hits, hit_map, overflow
    );
endinterface

// File: rtl/seq_detect_frame_ctrl.sv
// rtl/seq_detect_frame_ctrl.sv - frame sequencer feeding a serial sequence detector
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   ctl          slave side of the request/result bundle
//   det_reset_n  detector reset, low during reset_n and the CLR cycle
//   det_x        serial frame bit to the detector, MSB first
//   det_y        detector output, attributed back to frame bits
module seq_detect_frame_ctrl #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 5,
    parameter int DET_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seq_detect_frame_ctrl_if.slave  ctl,
    output logic                    det_reset_n,
    output logic                    det_x,
    input  logic                    det_y
);
    localparam int CYC_W = $clog2(WIDTH + DET_LAT + 1);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] HITS_MAX  = '1;
    localparam logic [CYC_W-1:0] LAST_BIT  = CYC_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(WIDTH + DET_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [WIDTH-1:0] hit_map_q, hit_map_d;
    logic             overflow_q, overflow_d;
    logic             clr_q, clr_d;
    logic             hit;
    int               bit_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            cyc_q      <= '0;
            hits_q     <= '0;
            hit_map_q  <= '0;
            overflow_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cyc_q      <= cyc_d;
            hits_q     <= hits_d;
            hit_map_q  <= hit_map_d;
            overflow_q <= overflow_d;
            clr_q      <= clr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cyc_d      = cyc_q;
        hits_d     = hits_q;
        hit_map_d  = hit_map_q;
        overflow_d = overflow_q;
        hit        = 1'b0;
        bit_idx    = 0;

        case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    sreg_d     = ctl.frame;
                    cyc_d      = '0;
                    hits_d     = '0;
                    hit_map_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = ctl.clear_det ? ST_CLR : ST_SHIFT;
                end
            end
            ST_CLR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cyc_d  = cyc_q + CYC_W'(1);
                // cyc_q counts cycles since SHIFT cycle 0; samples earlier than
                // the detector latency belong to no bit of this frame.
                hit    = det_y && (int'(cyc_q) >= DET_LAT);
                if (cyc_q == LAST_BIT) begin
                    state_d = (DET_LAT > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                cyc_d = cyc_q + CYC_W'(1);
                hit   = det_y && (int'(cyc_q) >= DET_LAT);
                if (cyc_q == LAST_CYC) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hit) begin
            // Sample cycle t maps to frame bit k = t - DET_LAT, sent MSB first.
            bit_idx = WIDTH - 1 - (int'(cyc_q) - DET_LAT);
            hit_map_d[IDX_W'(bit_idx)] = 1'b1;
            if (hits_q == HITS_MAX) begin
                overflow_d = 1'b1;
            end else begin
                hits_d = hits_q + CNT_W'(1);
            end
        end
    end

    // Registered so the detector reset is a clean one-cycle pulse in CLR.
    assign clr_d = (state_d == ST_CLR);

    assign ctl.busy     = (state_q == ST_CLR) || (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
    assign ctl.done     = (state_q == ST_DONE);
    assign ctl.hits     = hits_q;
    assign ctl.hit_map  = hit_map_q;
    assign ctl.overflow = overflow_q;

    assign det_x        = (state_q == ST_SHIFT) & sreg_q[WIDTH-1];
    assign det_reset_n  = reset_n & ~clr_q;
endmodule

// File: tb/tb_seq_detect_frame_ctrl.sv
// tb/tb_seq_detect_frame_ctrl.sv - directed bench for the frame sequencer with detector stubs
module tb_seq_detect_frame_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    seq_detect_frame_ctrl_if #(.WIDTH(16), .CNT_W(5)) bus ();
    seq_detect_frame_ctrl_if #(.WIDTH(16), .CNT_W(3)) bus_b ();

    logic det_reset_n, det_x, det_y, echo_q, y_const;
    logic det_reset_n_b, det_x_b, det_y_b, echo_b_q;

    seq_detect_frame_ctrl #(.WIDTH(16), .CNT_W(5), .DET_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .ctl(bus.slave),
        .det_reset_n(det_reset_n), .det_x(det_x), .det_y(det_y)
    );

    seq_detect_frame_ctrl #(.WIDTH(16), .CNT_W(3), .DET_LAT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .ctl(bus_b.slave),
        .det_reset_n(det_reset_n_b), .det_x(det_x_b), .det_y(det_y_b)
    );

    // Detector stubs: y is x delayed one clock, cleared by the detector reset.
    always @(posedge clk or negedge det_reset_n)
        if (!det_reset_n) echo_q <= 1'b0; else echo_q <= det_x;
    assign det_y = y_const ? 1'b1 : echo_q;

    always @(posedge clk or negedge det_reset_n_b)
        if (!det_reset_n_b) echo_b_q <= 1'b0; else echo_b_q <= det_x_b;
    assign det_y_b = echo_b_q;

    int   total = 0;
    int   bad   = 0;
    logic hold  = 1'b0;
    logic use_b = 1'b0;
    int   pulse_at = -1;

    int          d1, d2, rl, bl;
    logic [15:0] xs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start and watches `win` cycles; cycle n is sampled at the
    // n-th falling edge after the accepting edge E0.
    task automatic run(input logic [15:0] f, input logic cd, input int win,
                       output int done1, output int done2, output logic [15:0] xbits,
                       output int rst_low, output int busy_low);
        @(negedge clk);
        bus.start = 1'b1; bus.frame = f; bus.clear_det = cd;
        if (use_b) begin
            bus_b.start = 1'b1; bus_b.frame = f; bus_b.clear_det = cd;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        bus_b.start = 1'b0;
        done1 = -1; done2 = -1; xbits = '0; rst_low = 0; busy_low = 0;
        for (int n = 1; n <= win; n++) begin
            @(negedge clk);
            if (!det_reset_n) rst_low++;
            if (!bus.busy) busy_low++;
            if (n >= 1 + int'(cd) && n <= 16 + int'(cd)) xbits = {xbits[14:0], det_x};
            if (bus.done) begin
                if (done1 < 0) done1 = n;
                else if (done2 < 0) done2 = n;
            end
            if (n == pulse_at) begin
                bus.start = 1'b1; bus.frame = 16'hFFFF;
            end else if (n == pulse_at + 1) begin
                bus.start = 1'b0; bus.frame = f;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; y_const = 1'b0;
        bus.start = 1'b0; bus.frame = '0; bus.clear_det = 1'b0;
        bus_b.start = 1'b0; bus_b.frame = '0; bus_b.clear_det = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hits", bus.hits, 0);
        chk("rst_map", bus.hit_map, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_detx", det_x, 0);
        chk("rst_detrst", det_reset_n, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_detrst", det_reset_n, 1);

        // Plain frame, echo stub
        run(16'h5A5A, 1'b0, 20, d1, d2, xs, rl, bl);
        chk("t2_stream", xs, 16'h5A5A);
        chk("t2_done_at", d1, 18);
        chk("t2_done_once", d2, -1);
        chk("t2_hits", bus.hits, 8);
        chk("t2_map", bus.hit_map, 16'h5A5A);
        chk("t2_ovf", bus.overflow, 0);
        chk("t2_no_detrst", rl, 0);

        // Same frame with a detector clear first
        run(16'h5A5A, 1'b1, 21, d1, d2, xs, rl, bl);
        chk("t3_stream", xs, 16'h5A5A);
        chk("t3_done_at", d1, 19);
        chk("t3_detrst_len", rl, 1);
        chk("t3_hits", bus.hits, 8);
        chk("t3_map", bus.hit_map, 16'h5A5A);

        // All ones: saturation on the 3-bit counter build, none on the 5-bit one
        use_b = 1'b1;
        run(16'hFFFF, 1'b0, 20, d1, d2, xs, rl, bl);
        use_b = 1'b0;
        chk("t4_a_hits", bus.hits, 16);
        chk("t4_a_ovf", bus.overflow, 0);
        chk("t4_b_hits", bus_b.hits, 7);
        chk("t4_b_ovf", bus_b.overflow, 1);
        chk("t4_b_map", bus_b.hit_map, 16'hFFFF);

        // Constant y: SHIFT cycle 0 sample dropped, IDLE/DONE samples ignored
        y_const = 1'b1;
        run(16'h0000, 1'b0, 20, d1, d2, xs, rl, bl);
        chk("t6_hits", bus.hits, 16);
        chk("t6_map", bus.hit_map, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("t6_hits_hold", bus.hits, 16);
        y_const = 1'b0;

        // Start held high: back-to-back frames separated by DONE and one IDLE
        hold = 1'b1;
        run(16'h5A5A, 1'b0, 40, d1, d2, xs, rl, bl);
        hold = 1'b0;
        bus.start = 1'b0;
        chk("t5_done1", d1, 18);
        chk("t5_done2", d2, 37);
        chk("t5_busy_low", bl, 4);
        repeat (20) @(negedge clk);

        // Start pulse mid-frame is ignored
        pulse_at = 5;
        run(16'h5A5A, 1'b0, 40, d1, d2, xs, rl, bl);
        chk("t5_mid_done", d1, 18);
        chk("t5_mid_none", d2, -1);
        chk("t5_mid_hits", bus.hits, 8);
        chk("t5_mid_map", bus.hit_map, 16'h5A5A);

        // Start pulse in the DONE cycle is ignored
        pulse_at = 18;
        run(16'h3C00, 1'b0, 40, d1, d2, xs, rl, bl);
        pulse_at = -1;
        chk("t5_done_pulse_d1", d1, 18);
        chk("t5_done_pulse_none", d2, -1);
        chk("t5_done_pulse_map", bus.hit_map, 16'h3C00);

        // Reset in the middle of SHIFT
        @(negedge clk);
        bus.start = 1'b1; bus.frame = 16'hFFFF; bus.clear_det = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t1_pre_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t1_busy", bus.busy, 0);
        chk("t1_detx", det_x, 0);
        chk("t1_detrst", det_reset_n, 0);
        chk("t1_hits", bus.hits, 0);
        chk("t1_map", bus.hit_map, 0);
        @(negedge clk);
        reset_n = 1'b1;
        d1 = 0; bl = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.done) d1++;
            if (bus.busy) bl++;
        end
        chk("t1_no_done", d1, 0);
        chk("t1_stays_idle", bl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
